kyber_hpm_cmd_shell: RTL

KYBER_HPM_CMD_SHELL -- requirements
Module: kyber_hpm_cmd_shell

---
 rtl/kyber_hpm_cmd_shell_if.sv | 47 ++++
 rtl/kyber_hpm_cmd_shell.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/kyber_hpm_cmd_shell_if.sv
// Host and core signal bundle for the Kyber HPM command shell.
// The shell takes the slave modport; the host/core side takes master.
interface kyber_hpm_cmd_shell_if #(
  parameter int PE_NUMBER = 16
);
  logic                      cmd_valid;
  logic [3:0]                cmd_op;
  logic                      cmd_ready;
  logic                      din_valid;
  logic [12*PE_NUMBER-1:0]   din;
  logic                      dout_valid;
  logic [12*PE_NUMBER-1:0]   dout;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic [1:0]                err_code;
  logic                      core_load_a_f;
  logic                      core_load_a_i;
  logic                      core_load_b_f;
  logic                      core_load_b_i;
  logic                      core_read_a;
  logic                      core_read_b;
  logic                      core_start_ab;
  logic                      core_start_fntt;
  logic                      core_start_pwm2;
  logic                      core_start_intt;
  logic                      core_din_valid;
  logic [12*PE_NUMBER-1:0]   core_din;
  logic [12*PE_NUMBER-1:0]   core_dout;
  logic                      core_done;

  modport master (
    output cmd_valid, cmd_op, din_valid, din, core_dout, core_done,
    input  cmd_ready, dout_valid, dout, busy, done, err, err_code,
    input  core_load_a_f, core_load_a_i, core_load_b_f, core_load_b_i,
    input  core_read_a, core_read_b, core_start_ab, core_start_fntt,
    input  core_start_pwm2, core_start_intt, core_din_valid, core_din
  );

  modport slave (
    input  cmd_valid, cmd_op, din_valid, din, core_dout, core_done,
    output cmd_ready, dout_valid, dout, busy, done, err, err_code,
    output core_load_a_f, core_load_a_i, core_load_b_f, core_load_b_i,
    output core_read_a, core_read_b, core_start_ab, core_start_fntt,
    output core_start_pwm2, core_start_intt, core_din_valid, core_din
  );
endinterface

// File: rtl/kyber_hpm_cmd_shell.sv
// Kyber HPM command shell: opcode -> one-cycle core pulse, then load/read/compute sequencing.
// Pulse 1 cycle after acceptance; din/dout delayed IN_STAGES/OUT_STAGES; cmd_ready held low unless IDLE.
module kyber_hpm_cmd_shell #(
  parameter int PE_NUMBER  = 16,
  parameter int IN_STAGES  = 1,
  parameter int OUT_STAGES = 1,
  parameter int BEATS      = 256 / PE_NUMBER,
  parameter int TIMEOUT    = 4095
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  kyber_hpm_cmd_shell_if.slave sh_if
);
  localparam int W     = 12 * PE_NUMBER;
  localparam int CNT_W = $clog2(TIMEOUT + BEATS + 8);
  localparam int IN_N  = (IN_STAGES > 0) ? IN_STAGES : 1;
  localparam int OUT_N = (OUT_STAGES > 0) ? OUT_STAGES : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_LOAD, S_READ, S_COMPUTE, S_DONE
  } state_e;

  state_e           state_q;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic [1:0]       err_code_q;
  logic [9:0]       pulse_q;

  logic op_legal;
  logic load_beat;
  logic rd_vld;

  assign cnt_d     = cnt_q + 1'b1;
  assign op_legal  = (sh_if.cmd_op <= 4'd9);
  // Beats past the last one are dropped so the core never sees more than BEATS.
  assign load_beat = (state_q == S_LOAD) && (cnt_q < CNT_W'(BEATS)) && sh_if.din_valid;
  assign rd_vld    = (state_q == S_READ) && (cnt_q < CNT_W'(BEATS));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      pulse_q    <= '0;
    end else begin
      pulse_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (sh_if.cmd_valid) begin
            if (op_legal) begin
              op_q       <= sh_if.cmd_op;
              pulse_q    <= 10'd1 << sh_if.cmd_op;
              err_q      <= 1'b0;
              err_code_q <= 2'd0;
              cnt_q      <= '0;
              state_q    <= S_ISSUE;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'd1;
            end
          end
        end
        S_ISSUE: begin
          cnt_q <= '0;
          if (op_q <= 4'd3)      state_q <= S_LOAD;
          else if (op_q <= 4'd5) state_q <= S_READ;
          else                   state_q <= S_COMPUTE;
        end
        S_LOAD: begin
          // Counter runs past BEATS unconditionally to drain the input pipeline.
          if (load_beat || (cnt_q >= CNT_W'(BEATS))) begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_W'(BEATS + IN_STAGES)) state_q <= S_DONE;
          end
        end
        S_READ: begin
          cnt_q <= cnt_d;
          if (cnt_d == CNT_W'(BEATS + OUT_STAGES)) state_q <= S_DONE;
        end
        S_COMPUTE: begin
          // core_done wins over a coincident watchdog expiry.
          if (sh_if.core_done) begin
            state_q <= S_DONE;
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            err_q      <= 1'b1;
            err_code_q <= 2'd2;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [IN_N-1:0]  in_vld_q;
  logic [W-1:0]     in_dat_q [IN_N];
  logic [OUT_N-1:0] out_vld_q;
  logic [W-1:0]     out_dat_q [OUT_N];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      in_vld_q <= '0;
      for (int k = 0; k < IN_N; k++) in_dat_q[k] <= '0;
    end else begin
      in_vld_q[0] <= load_beat;
      in_dat_q[0] <= sh_if.din;
      for (int k = 1; k < IN_N; k++) begin
        in_vld_q[k] <= in_vld_q[k-1];
        in_dat_q[k] <= in_dat_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_vld_q <= '0;
      for (int k = 0; k < OUT_N; k++) out_dat_q[k] <= '0;
    end else begin
      out_vld_q[0] <= rd_vld;
      out_dat_q[0] <= sh_if.core_dout;
      for (int k = 1; k < OUT_N; k++) begin
        out_vld_q[k] <= out_vld_q[k-1];
        out_dat_q[k] <= out_dat_q[k-1];
      end
    end
  end

  generate
    if (IN_STAGES == 0) begin : g_in_comb
      assign sh_if.core_din_valid = load_beat;
      assign sh_if.core_din       = sh_if.din;
    end else begin : g_in_reg
      assign sh_if.core_din_valid = in_vld_q[IN_STAGES-1];
      assign sh_if.core_din       = in_dat_q[IN_STAGES-1];
    end
    if (OUT_STAGES == 0) begin : g_out_comb
      assign sh_if.dout_valid = rd_vld;
      assign sh_if.dout       = sh_if.core_dout;
    end else begin : g_out_reg
      assign sh_if.dout_valid = out_vld_q[OUT_STAGES-1];
      assign sh_if.dout       = out_dat_q[OUT_STAGES-1];
    end
  endgenerate

  assign sh_if.cmd_ready       = (state_q == S_IDLE);
  assign sh_if.busy            = (state_q != S_IDLE);
  assign sh_if.done            = (state_q == S_DONE);
  assign sh_if.err             = err_q;
  assign sh_if.err_code        = err_code_q;
  assign sh_if.core_load_a_f   = pulse_q[0];
  assign sh_if.core_load_a_i   = pulse_q[1];
  assign sh_if.core_load_b_f   = pulse_q[2];
  assign sh_if.core_load_b_i   = pulse_q[3];
  assign sh_if.core_read_a     = pulse_q[4];
  assign sh_if.core_read_b     = pulse_q[5];
  assign sh_if.core_start_ab   = pulse_q[6];
  assign sh_if.core_start_fntt = pulse_q[7];
  assign sh_if.core_start_pwm2 = pulse_q[8];
  assign sh_if.core_start_intt = pulse_q[9];
endmodule
